// File: rtl/systolic_feeder_pkg.sv
// Shared constants, matrix/skew types and the controller state encoding
// for the 4x4 systolic array front end.
package systolic_pkg;

  localparam int N            = 4;
  localparam int DATA_W       = 8;
  localparam int ACC_W        = 16;
  localparam int DRAIN_CYCLES = 4;

  // Each array input port is a 2N-1 deep skew line; only element 0 is fed.
  localparam int SKEW_W       = 2 * N - 1;
  // Feed cycles run cnt = 0 .. 2N-2 so the last diagonal reaches lane N-1.
  localparam int FEED_LAST    = 2 * N - 2;
  localparam int CAPTURE_AT   = FEED_LAST + DRAIN_CYCLES;
  localparam int CNT_W        = $clog2(CAPTURE_AT + 1);
  localparam int LANE_W       = $clog2(N);

  typedef logic [N-1:0][DATA_W-1:0]             vec8_t;
  typedef logic [N-1:0][N-1:0][DATA_W-1:0]      mat8_t;
  typedef logic [N-1:0][N-1:0][ACC_W-1:0]       mat16_t;
  typedef logic [N-1:0][SKEW_W-1:0][DATA_W-1:0] skew_t;
  typedef logic [CNT_W-1:0]                     cnt_t;
  typedef logic [LANE_W-1:0]                    lane_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/systolic_feeder_skew_lane.sv
// Combinational lane selector: lane L emits vec[cnt-L] while that index
// lies inside the operand vector, producing the diagonal skew.
module skew_lane
  import systolic_pkg::*;
(
  input  logic              en,
  input  lane_t             lane,
  input  vec8_t             vec,
  input  cnt_t              cnt,
  output logic [DATA_W-1:0] data
);

  cnt_t offset;

  // Pick the operand whose index equals cnt minus the lane number, else zero
  always_comb begin
    data   = '0;
    offset = cnt - cnt_t'(lane);
    if (en && (cnt >= cnt_t'(lane)) && (offset <= cnt_t'(N - 1))) begin
      data = vec[offset[LANE_W-1:0]];
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Front-end controller: accepts A and B, streams them skewed into the
// systolic array, waits for the drain and returns C as an accumulator delta.
module systolic_feeder
  import systolic_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_srst,
  input  mat8_t  i_a_mat,
  input  mat8_t  i_b_mat,
  input  logic   i_valid,
  output logic   o_ready,
  output skew_t  o_row,
  output skew_t  o_col,
  input  mat16_t i_c,
  output mat16_t o_result,
  output logic   o_result_valid,
  input  logic   i_result_ready
);

  feeder_state_t state;
  feeder_state_t state_next;
  cnt_t          cnt;
  mat8_t         a_reg;
  mat8_t         b_reg;
  mat16_t        baseline;
  logic          feed_en;
  mat8_t         col_vec;
  vec8_t         row_byte;
  vec8_t         col_byte;

  // State register; reset returns to IDLE and abandons any job in flight
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the handshake and feed-enable outputs
  always_comb begin
    state_next     = state;
    o_ready        = 1'b0;
    o_result_valid = 1'b0;
    feed_en        = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          state_next = FEED;
        end
      end
      FEED: begin
        feed_en = 1'b1;
        if (cnt == cnt_t'(FEED_LAST)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt == cnt_t'(CAPTURE_AT)) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        o_result_valid = 1'b1;
        if (i_result_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, baseline snapshot, cycle counter and result delta.
  // The baseline is taken in IDLE where the array only sees zeros, so the
  // delta after the drain is exactly this job's contribution, mod 2^ACC_W.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      cnt      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      baseline <= '0;
      o_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            a_reg    <= i_a_mat;
            b_reg    <= i_b_mat;
            baseline <= i_c;
            cnt      <= '0;
          end
        end
        FEED: begin
          cnt <= cnt + cnt_t'(1);
        end
        DRAIN: begin
          cnt <= cnt + cnt_t'(1);
          if (cnt == cnt_t'(CAPTURE_AT)) begin
            for (int i = 0; i < N; i++) begin
              for (int j = 0; j < N; j++) begin
                o_result[i][j] <= i_c[i][j] - baseline[i][j];
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Rows take A[i][*] directly; columns need B transposed into B[*][j].
  for (genvar g = 0; g < N; g++) begin : g_lane
    for (genvar k = 0; k < N; k++) begin : g_colvec
      assign col_vec[g][k] = b_reg[k][g];
    end

    skew_lane u_row_lane (
      .en   (feed_en),
      .lane (lane_t'(g)),
      .vec  (a_reg[g]),
      .cnt  (cnt),
      .data (row_byte[g])
    );

    skew_lane u_col_lane (
      .en   (feed_en),
      .lane (lane_t'(g)),
      .vec  (col_vec[g]),
      .cnt  (cnt),
      .data (col_byte[g])
    );

    assign o_row[g][0]          = row_byte[g];
    assign o_row[g][SKEW_W-1:1] = '0;
    assign o_col[g][0]          = col_byte[g];
    assign o_col[g][SKEW_W-1:1] = '0;
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder with a behavioural 4x4
// output-stationary array attached and a plain matrix-multiply reference.
module tb_systolic_feeder;
  import systolic_pkg::*;

  logic   clk = 1'b0;
  logic   srst;
  mat8_t  a_mat;
  mat8_t  b_mat;
  logic   valid;
  logic   ready;
  skew_t  row;
  skew_t  col;
  mat16_t c_bus;
  mat16_t result;
  logic   result_valid;
  logic   result_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  systolic_feeder dut (
    .i_clk          (clk),
    .i_srst         (srst),
    .i_a_mat        (a_mat),
    .i_b_mat        (b_mat),
    .i_valid        (valid),
    .o_ready        (ready),
    .o_row          (row),
    .o_col          (col),
    .i_c            (c_bus),
    .o_result       (result),
    .o_result_valid (result_valid),
    .i_result_ready (result_ready)
  );

  // Behavioural array: operands hop one PE per clock, accumulators never clear
  logic [7:0]  a_pipe [N][N];
  logic [7:0]  b_pipe [N][N];
  logic [7:0]  a_in   [N][N];
  logic [7:0]  b_in   [N][N];
  logic [15:0] acc    [N][N];
  logic        arr_load;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_in[i][0] = row[i][0];
      for (int j = 1; j < N; j++) a_in[i][j] = a_pipe[i][j-1];
    end
    for (int j = 0; j < N; j++) begin
      b_in[0][j] = col[j][0];
      for (int i = 1; i < N; i++) b_in[i][j] = b_pipe[i-1][j];
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) c_bus[i][j] = acc[i][j];
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (arr_load) begin
          acc[i][j]    <= 16'($urandom);
          a_pipe[i][j] <= '0;
          b_pipe[i][j] <= '0;
        end else begin
          acc[i][j]    <= acc[i][j] + 16'(a_in[i][j] * b_in[i][j]);
          a_pipe[i][j] <= a_in[i][j];
          b_pipe[i][j] <= b_in[i][j];
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic mat16_t matmul(input mat8_t a, input mat8_t b);
    mat16_t r;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        int s = 0;
        for (int k = 0; k < N; k++) s += int'(a[i][k]) * int'(b[k][j]);
        r[i][j] = 16'(s);
      end
    end
    return r;
  endfunction

  function automatic skew_t exp_rows(input mat8_t a, input int c);
    skew_t r = '0;
    for (int i = 0; i < N; i++) begin
      int k = c - i;
      if (k >= 0 && k < N) r[i][0] = a[i][k];
    end
    return r;
  endfunction

  function automatic skew_t exp_cols(input mat8_t b, input int c);
    skew_t r = '0;
    for (int j = 0; j < N; j++) begin
      int k = c - j;
      if (k >= 0 && k < N) r[j][0] = b[k][j];
    end
    return r;
  endfunction

  function automatic mat8_t rand_mat();
    mat8_t m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) m[i][j] = 8'($urandom);
    return m;
  endfunction

  function automatic mat8_t fill_mat(input logic [7:0] v);
    mat8_t m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) m[i][j] = v;
    return m;
  endfunction

  function automatic mat16_t fill_res(input logic [15:0] v);
    mat16_t m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) m[i][j] = v;
    return m;
  endfunction

  function automatic mat8_t identity();
    mat8_t m = '0;
    for (int i = 0; i < N; i++) m[i][i] = 8'd1;
    return m;
  endfunction

  // Stimulus helpers: entered and left just after a falling edge
  task automatic applyStimulus(input mat8_t a, input mat8_t b);
    a_mat = a;
    b_mat = b;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    a_mat = rand_mat();
    b_mat = rand_mat();
  endtask

  task automatic wait_result(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (result_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic release_result();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    srst = 1'b1; valid = 1'b0; result_ready = 1'b0;
    a_mat = '0; b_mat = '0; arr_load = 1'b1;
    repeat (3) @(negedge clk);
    srst = 1'b0; arr_load = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", ready); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid: got %b expected 0", result_valid); end
    checks++; if (row !== '0) begin errors++; $display("[TB] FAIL reset_row: got %h expected 0", row); end
    checks++; if (col !== '0) begin errors++; $display("[TB] FAIL reset_col: got %h expected 0", col); end
    checks++; if (result !== '0) begin errors++; $display("[TB] FAIL reset_result: got %h expected 0", result); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_skew();
    mat8_t a;
    int lat;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) a[i][k] = 8'(16 * i + k + 1);
    applyStimulus(a, '0);
    for (int c = 0; c <= FEED_LAST; c++) begin
      checks++; if (row !== exp_rows(a, c)) begin errors++; $display("[TB] FAIL skew_row c=%0d: got %h expected %h", c, row, exp_rows(a, c)); end
      checks++; if (col !== '0) begin errors++; $display("[TB] FAIL skew_col c=%0d: got %h expected 0", c, col); end
      if (c == 3) begin
        checks++; if (row[3][0] !== 8'h31 || row[0][0] !== 8'h04 || row[1][0] !== 8'h13)
          begin errors++; $display("[TB] FAIL skew_c3: got %h %h %h expected 31 04 13", row[3][0], row[0][0], row[1][0]); end
      end
      if (c == 6) begin
        checks++; if (row[3][0] !== 8'h34) begin errors++; $display("[TB] FAIL skew_c6: got %h expected 34", row[3][0]); end
      end
      @(negedge clk);
    end
    checks++; if (row !== '0) begin errors++; $display("[TB] FAIL skew_drain_row: got %h expected 0", row); end
    wait_result(lat);
    checks++; if (lat < 0) begin errors++; $display("[TB] FAIL skew_timeout: got no result expected one"); end
    checks++; if (result !== '0) begin errors++; $display("[TB] FAIL skew_result: got %h expected 0", result); end
    release_result();
  endtask

  task automatic test_identity();
    mat8_t b;
    int lat;
    for (int k = 0; k < N; k++)
      for (int j = 0; j < N; j++) b[k][j] = 8'(4 * k + j);
    applyStimulus(identity(), b);
    wait_result(lat);
    checks++; if (lat !== 11) begin errors++; $display("[TB] FAIL ident_latency: got %0d expected 11", lat); end
    checks++; if (result !== matmul(identity(), b)) begin errors++; $display("[TB] FAIL ident_result: got %h expected %h", result, matmul(identity(), b)); end
    release_result();
    checks++; if (result_valid !== 1'b0 || ready !== 1'b1) begin errors++; $display("[TB] FAIL ident_release: got rv=%b rdy=%b expected 0 1", result_valid, ready); end
    checks++; if (result !== matmul(identity(), b)) begin errors++; $display("[TB] FAIL ident_keep: got %h expected %h", result, matmul(identity(), b)); end
  endtask

  task automatic test_back_to_back();
    int lat;
    applyStimulus(fill_mat(8'hFF), fill_mat(8'hFF));
    wait_result(lat);
    checks++; if (lat !== 11) begin errors++; $display("[TB] FAIL ovf_latency: got %0d expected 11", lat); end
    checks++; if (result !== fill_res(16'hF804)) begin errors++; $display("[TB] FAIL ovf_result: got %h expected all f804", result); end
    release_result();
    applyStimulus(fill_mat(8'h01), fill_mat(8'h01));
    wait_result(lat);
    checks++; if (result !== fill_res(16'd4)) begin errors++; $display("[TB] FAIL b2b_result: got %h expected all 0004", result); end
    release_result();
  endtask

  task automatic test_backpressure();
    mat8_t a1 = rand_mat(), b1 = rand_mat(), a2 = rand_mat(), b2 = rand_mat();
    int lat;
    applyStimulus(a1, b1);
    wait_result(lat);
    a_mat = a2; b_mat = b2; valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      checks++; if (result !== matmul(a1, b1) || ready !== 1'b0 || result_valid !== 1'b1)
        begin errors++; $display("[TB] FAIL bp_hold k=%0d: got res=%h rdy=%b rv=%b expected res=%h rdy=0 rv=1", k, result, ready, result_valid, matmul(a1, b1)); end
      @(negedge clk);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    checks++; if (ready !== 1'b1 || result_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_idle: got rdy=%b rv=%b expected 1 0", ready, result_valid); end
    @(negedge clk);
    valid = 1'b0;
    a_mat = rand_mat(); b_mat = rand_mat();
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_accept: got rdy=%b expected 0", ready); end
    wait_result(lat);
    checks++; if (lat !== 11) begin errors++; $display("[TB] FAIL bp_latency: got %0d expected 11", lat); end
    checks++; if (result !== matmul(a2, b2)) begin errors++; $display("[TB] FAIL bp_result: got %h expected %h", result, matmul(a2, b2)); end
    release_result();
  endtask

  task automatic test_reset_mid_feed();
    mat8_t b = rand_mat();
    int lat;
    applyStimulus(rand_mat(), rand_mat());
    repeat (3) @(negedge clk);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    checks++; if (ready !== 1'b1 || result_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_hs: got rdy=%b rv=%b expected 1 0", ready, result_valid); end
    checks++; if (row !== '0 || col !== '0) begin errors++; $display("[TB] FAIL rst_mid_feed: got row=%h col=%h expected 0", row, col); end
    checks++; if (result !== '0) begin errors++; $display("[TB] FAIL rst_mid_result: got %h expected 0", result); end
    repeat (5) @(negedge clk);
    applyStimulus(identity(), b);
    wait_result(lat);
    checks++; if (result !== matmul(identity(), b)) begin errors++; $display("[TB] FAIL rst_mid_ident: got %h expected %h", result, matmul(identity(), b)); end
    release_result();
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      mat8_t a = rand_mat(), b = rand_mat();
      int lat;
      applyStimulus(a, b);
      for (int c = 0; c <= FEED_LAST; c++) begin
        checks++; if (row !== exp_rows(a, c) || col !== exp_cols(b, c))
          begin errors++; $display("[TB] FAIL rand_feed n=%0d c=%0d: got row=%h col=%h expected row=%h col=%h", n, c, row, col, exp_rows(a, c), exp_cols(b, c)); end
        @(negedge clk);
      end
      wait_result(lat);
      checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL rand_latency n=%0d: got %0d expected 4 after feed", n, lat); end
      checks++; if (result !== matmul(a, b)) begin errors++; $display("[TB] FAIL rand_result n=%0d: got %h expected %h", n, result, matmul(a, b)); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_result();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_skew();
    test_identity();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_feed();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Front-end controller for the 4x4 output-stationary systolic array multiplier.
- Accepts one pair of 4x4 8-bit matrices (A, B) over a valid/ready handshake.
- Drives A and B into the array's row and column inputs as diagonally skewed streams.
- Waits for the array pipeline to drain, then returns C = A x B over a second valid/ready handshake. The array has no clear input, so each result is the delta between the array accumulators after the job and before it.

Parameters:
- N, 4, array dimension; fixed at 4 for this revision.
- DATA_W, 8, operand width.
- ACC_W, 16, accumulator/result width; must match the array's o_c element width.
- DRAIN, 4, cycles after the last feed cycle until the o_c capture.

Ports:
- i_clk  in  1  clock
- i_srst  in  1  synchronous active-high reset
- i_a_mat  in  [3:0][3:0][7:0]  matrix A, indexed [row][k]
- i_b_mat  in  [3:0][3:0][7:0]  matrix B, indexed [k][col]
- i_valid  in  1  job request
- o_ready  out  1  job accept
- o_row  out  [3:0][6:0][7:0]  to array i_row; only [i][0] is driven, [i][6:1] are tied 0
- o_col  out  [3:0][6:0][7:0]  to array i_col; only [j][0] is driven, [j][6:1] are tied 0
- i_c  in  [3:0][3:0][15:0]  from array o_c
- o_result  out  [3:0][3:0][15:0]  C, indexed [row][col]
- o_result_valid  out  1  result available
- i_result_ready  in  1  result consumed

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_srst is synchronous, active-high, and dominates every other event.
- Reset values: state IDLE; o_ready=1 from the first cycle after reset; o_row, o_col, o_result all 0; o_result_valid=0; counter 0.
- States: IDLE -> FEED -> DRAIN -> HOLD -> IDLE.
- IDLE:
  - o_ready=1.
  - On i_valid&&o_ready: register i_a_mat and i_b_mat; register baseline <= i_c; cnt <= 0; go to FEED.
- FEED (cnt = 0..6), feed cycle c = cnt:
  - o_row[i][0] = A[i][c-i] when 0 <= c-i <= 3, else 0.
  - o_col[j][0] = B[c-j][j] when 0 <= c-j <= 3, else 0.
  - cnt increments each cycle; at cnt==6 go to DRAIN.
- Outside FEED, o_row and o_col are all 0. Zero operands add nothing to the PE accumulators.
- DRAIN:
  - cnt continues incrementing.
  - In the cycle where cnt == 6+DRAIN (cycle 10 at default), register o_result[i][j] <= i_c[i][j] - baseline[i][j], then go to HOLD.
  - The last product reaches PE(3,3) in cycle 9 and is visible on o_c in cycle 10.
- HOLD:
  - o_result_valid=1; o_result stays stable.
  - On i_result_ready: go to IDLE next cycle. o_result_valid drops; o_result keeps its value.
  - No same-cycle re-accept.
- Arithmetic:
  - Subtraction is unsigned, mod 2^ACC_W; this gives correct deltas across accumulator wrap.
  - Products are treated as unsigned 8x8; the true dot-product max is 260100, so C is reported mod 2^16.
- Throughput: 1 accept cycle + 7 FEED + DRAIN + at least 1 HOLD cycle per job.
- Boundary conditions:
  - i_valid is ignored outside IDLE.
  - i_a_mat and i_b_mat may change freely after accept.
  - i_result_ready is ignored outside HOLD.
  - Reset mid-job aborts to IDLE with zeroed outputs and discards the job. The array's accumulators are not touched; the next job's baseline capture absorbs any partial sums.
  - The baseline is sampled only in IDLE, while the array receives zeros and o_c is therefore stable.

Decomposition:
- Package systolic_pkg holds:
  - constants N=4, DATA_W=8, ACC_W=16;
  - typedefs mat8_t [3:0][3:0][7:0] and mat16_t [3:0][3:0][15:0];
  - typedef skew_t [3:0][6:0][7:0];
  - enum feeder_state_t {IDLE, FEED, DRAIN, HOLD}.
- One natural sub-module, skew_lane: a combinational lane selector. Given a lane index, the 4-element operand vector and cnt, it outputs the skewed byte. It is instantiated 4x for rows and 4x for cols.

Test Plan:
- Skew check: A[i][k] = 16*i+k+1, B = 0.
  - Response: cycle c=3 gives o_row[3][0]=0x31, o_row[0][0]=0x04, o_row[1][0]=0x13. Cycle c=6 gives only o_row[3][0]=0x34 nonzero.
  - With the array attached, o_result is all 0.
- Identity: A = I, B[k][j] = 4*k+j (via array model).
  - Response: o_result_valid asserts exactly 11 cycles after the accept edge; o_result == B.
- Overflow: A and B all 0xFF.
  - Response: every o_result element = 260100 mod 65536 = 63492 (0xF804).
- Back-to-back: run the overflow job, then A = B = all 1 without resetting the array.
  - Response: second result is all 4, which proves baseline subtraction across accumulator wrap.
- Backpressure: hold i_result_ready=0 for 20 cycles in HOLD, and drive i_valid=1 throughout.
  - Response: o_result stable, o_ready=0, no new job accepted. A 1-cycle i_result_ready gives IDLE next cycle, and the pending job is accepted then.
- Reset mid-FEED: pulse i_srst at c=3.
  - Response: the next cycle shows IDLE, outputs 0, o_ready=1.
  - A subsequent identity job still returns the correct B despite residual partial sums in the array.
